// File: rtl/bus_sequencer.sv
// Instruction sequencer for a shared 3-bit datapath bus: decodes MV/MVI/ADD/SUB
// and emits one-cycle Moore strobes for the register bank, accumulator A and G.
module bus_sequencer #(
    parameter int BUS_W    = 3,
    parameter int NUM_REGS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [5:0]          instr,
    input  logic [BUS_W-1:0]    din,
    inout  wire  [BUS_W-1:0]    bus,
    output logic [NUM_REGS-1:0] r_in,
    output logic [NUM_REGS-1:0] r_out,
    output logic                a_in,
    output logic                g_in,
    output logic                g_out,
    output logic                add_sub,
    output logic                done,
    output logic                busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    localparam logic [NUM_REGS-1:0] ONE_HOT_LSB = {{(NUM_REGS-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [5:0]          ir_q, ir_d;
    logic [1:0]          op_s, rx_s, ry_s;
    logic [NUM_REGS-1:0] rx_oh_s, ry_oh_s;
    logic                din_drive_s;

    assign op_s    = ir_q[5:4];
    assign rx_s    = ir_q[3:2];
    assign ry_s    = ir_q[1:0];
    assign rx_oh_s = ONE_HOT_LSB << rx_s;
    assign ry_oh_s = ONE_HOT_LSB << ry_s;

    // din is passed through live, so the bus reflects din during the MVI step itself
    assign bus = din_drive_s ? din : {BUS_W{1'bz}};

    // State and instruction register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state: run is only looked at in IDLE; MV/MVI finish in T1, ADD/SUB in T3
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    ir_d    = instr;
                    state_d = T1;
                end else begin
                    state_d = IDLE;
                end
            end
            T1: begin
                if (op_s[1]) begin
                    state_d = T2;
                end else begin
                    state_d = IDLE;
                end
            end
            T2:      state_d = T3;
            T3:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore strobe decode from state and IR
    always_comb begin
        r_in        = {NUM_REGS{1'b0}};
        r_out       = {NUM_REGS{1'b0}};
        a_in        = 1'b0;
        g_in        = 1'b0;
        g_out       = 1'b0;
        add_sub     = 1'b0;
        done        = 1'b0;
        din_drive_s = 1'b0;
        busy        = (state_q != IDLE);
        case (state_q)
            T1: begin
                case (op_s)
                    2'b00: begin
                        r_out = ry_oh_s;
                        r_in  = rx_oh_s;
                        done  = 1'b1;
                    end
                    2'b01: begin
                        din_drive_s = 1'b1;
                        r_in        = rx_oh_s;
                        done        = 1'b1;
                    end
                    default: begin
                        r_out = rx_oh_s;
                        a_in  = 1'b1;
                    end
                endcase
            end
            T2: begin
                r_out   = ry_oh_s;
                g_in    = 1'b1;
                add_sub = op_s[0];
            end
            T3: begin
                g_out = 1'b1;
                r_in  = rx_oh_s;
                done  = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: an instruction-level model predicts per-cycle
// strobes and register-file contents; a negedge monitor checks them and plays datapath.
module tb_bus_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic [5:0] instr = 6'd0;
    logic [2:0] din = 3'd0;
    wire  [2:0] bus;
    logic [3:0] r_in, r_out;
    logic       a_in, g_in, g_out, add_sub, done, busy;

    typedef struct packed {
        logic [3:0] r_in;
        logic [3:0] r_out;
        logic       a_in;
        logic       g_in;
        logic       g_out;
        logic       add_sub;
        logic       done;
        logic       busy;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  mvi;
    } exp_t;

    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         rem = 0;
    int         accepts = 0;
    int         dones = 0;
    logic [2:0] ref_r[4] = '{default: 3'd0};
    logic [2:0] dp_r[4]  = '{default: 3'd0};
    logic [2:0] dp_a = 3'd0;
    logic [2:0] dp_g = 3'd0;
    logic       pend_mvi = 1'b0;
    logic [1:0] pend_rx = 2'd0;
    outs_t      act_s;

    assign act_s = {r_in, r_out, a_in, g_in, g_out, add_sub, done, busy};

    bus_sequencer #(.BUS_W(3), .NUM_REGS(4)) dut (
        .clk(clk), .rst(rst), .run(run), .instr(instr), .din(din), .bus(bus),
        .r_in(r_in), .r_out(r_out), .a_in(a_in), .g_in(g_in), .g_out(g_out),
        .add_sub(add_sub), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] oh(input logic [1:0] i);
        logic [3:0] one;
        one = 4'b0001;
        return one << i;
    endfunction

    function automatic outs_t mk(input logic [3:0] ri, input logic [3:0] ro,
                                 input logic a, input logic g, input logic go,
                                 input logic as, input logic dn);
        return {ri, ro, a, g, go, as, dn, 1'b1};
    endfunction

    task automatic push(input outs_t o, input logic mvi);
        exp_t e;
        e.o   = o;
        e.mvi = mvi;
        q.push_back(e);
    endtask

    // Instruction-level reference: what each accepted instruction must do, step by step
    task automatic model_edge(input logic r, input logic [5:0] ins);
        logic [1:0] op, rx, ry;
        op = ins[5:4];
        rx = ins[3:2];
        ry = ins[1:0];
        if (rem == 0) begin
            if (r) begin
                accepts++;
                case (op)
                    2'b00: begin
                        push(mk(oh(rx), oh(ry), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b0);
                        ref_r[rx] = ref_r[ry];
                        rem = 1;
                    end
                    2'b01: begin
                        push(mk(oh(rx), 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), 1'b1);
                        pend_mvi = 1'b1;
                        pend_rx  = rx;
                        rem = 1;
                    end
                    default: begin
                        push(mk(4'd0, oh(rx), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
                        push(mk(4'd0, oh(ry), 1'b0, 1'b1, 1'b0, op[0], 1'b0), 1'b0);
                        push(mk(oh(rx), 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), 1'b0);
                        ref_r[rx] = op[0] ? ref_r[rx] - ref_r[ry] : ref_r[rx] + ref_r[ry];
                        rem = 3;
                    end
                endcase
            end
        end else begin
            rem--;
        end
    endtask

    task automatic step(input logic r, input logic [5:0] ins, input logic [2:0] d);
        run   = r;
        instr = ins;
        din   = d;
        if (pend_mvi) begin
            ref_r[pend_rx] = d;
            pend_mvi = 1'b0;
        end
        @(posedge clk);
        model_edge(r, ins);
        #1;
    endtask

    task automatic do_instr(input logic [5:0] ins, input logic [2:0] d);
        int guard;
        guard = 0;
        step(1'b1, ins, 3'($urandom));
        while (rem > 0 && guard < 10) begin
            step(1'b0, 6'($urandom), d);
            guard++;
        end
        step(1'b0, 6'($urandom), 3'($urandom));
    endtask

    // Monitor: pop expectation each cycle, check invariants, emulate the register bank
    always @(negedge clk) begin : monitor
        exp_t       e;
        logic [2:0] bv;
        if (!rst) begin
            if (q.size() > 0) begin
                e = q.pop_front();
            end else begin
                e = '0;
            end
            chk("outputs", 32'(act_s), 32'(e.o));
            if (e.mvi) chk("mvi_bus", 32'(bus), 32'(din));
            chk("bus_single_driver", 32'(($countones(r_out) + int'(g_out)) <= 1), 32'd1);
            chk("r_in_onehot0", 32'($onehot0(r_in)), 32'd1);
            chk("r_out_onehot0", 32'($onehot0(r_out)), 32'd1);
            if (done) dones++;
            bv = bus;
            for (int i = 0; i < 4; i++) if (r_out[i]) bv = dp_r[i];
            if (g_out) bv = dp_g;
            if (a_in) dp_a = bv;
            if (g_in) dp_g = add_sub ? dp_a - bv : dp_a + bv;
            for (int i = 0; i < 4; i++) if (r_in[i]) dp_r[i] = bv;
            if (done && q.size() == 0) begin
                for (int i = 0; i < 4; i++) chk("reg_file", 32'(dp_r[i]), 32'(ref_r[i]));
            end
        end
    end

    initial begin : stim
        logic [2:0] snap[4];
        int         target;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(act_s), 32'd0);
        rst = 1'b0;
        step(1'b0, 6'd0, 3'd0);

        do_instr({2'b01, 2'd1, 2'd0}, 3'd3);   // MVI R1,#3
        do_instr({2'b01, 2'd2, 2'd0}, 3'd6);   // MVI R2,#6

        snap = ref_r;
        step(1'b1, {2'b10, 2'd1, 2'd2}, 3'd0); // ADD R1,R2, aborted in T2
        step(1'b0, 6'd0, 3'd0);
        rst = 1'b1;
        #1;
        chk("abort_outputs", 32'(act_s), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        q.delete();
        rem      = 0;
        ref_r    = snap;
        pend_mvi = 1'b0;
        accepts--;
        #1;
        rst = 1'b0;
        step(1'b0, 6'd0, 3'd0);

        do_instr({2'b00, 2'd0, 2'd1}, 3'd0);   // MV R0,R1 after reset
        do_instr({2'b01, 2'd3, 2'd0}, 3'd5);   // MVI R3,#5
        do_instr({2'b00, 2'd0, 2'd3}, 3'd0);   // MV R0,R3
        do_instr({2'b10, 2'd1, 2'd2}, 3'd0);   // ADD R1,R2 -> 3+6 wraps to 1
        do_instr({2'b00, 2'd2, 2'd2}, 3'd0);   // MV R2,R2
        do_instr({2'b10, 2'd3, 2'd3}, 3'd0);   // ADD R3,R3 doubles
        do_instr({2'b01, 2'd2, 2'd0}, 3'd4);   // MVI R2,#4
        repeat (9) step(1'b1, {2'b11, 2'd2, 2'd2}, 3'($urandom)); // SUB R2,R2, run held
        repeat (3) step(1'b0, 6'd0, 3'd0);
        do_instr({2'b11, 2'd0, 2'd1}, 3'd0);   // SUB R0,R1: 5-1
        do_instr({2'b11, 2'd2, 2'd1}, 3'd0);   // SUB R2,R1: 0-1 wraps to 7

        target = accepts + 1000;
        for (int n = 0; n < 20000 && accepts < target; n++) begin
            step(1'($urandom), 6'($urandom), 3'($urandom));
        end
        chk("random_accepts_reached", 32'(accepts >= target), 32'd1);

        repeat (5) step(1'b0, 6'd0, 3'd0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("done_count", 32'(dones), 32'(accepts));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Control sequencer that drives the shared 3-bit datapath bus.
- Decodes one instruction per run pulse.
- Generates per-register in/out strobes for a bank of four bus registers, plus accumulator A and result register G.
- Drives the external data input onto the bus for immediate loads.
- Sits directly upstream of the bus registers and owns every bus-driver enable.

Parameters:
- BUS_W, 3, bus and data-input width.
- NUM_REGS, 4, number of general registers; fixed at 4 because instruction register fields are 2 bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- run  input  1  start request; sampled only in IDLE.
- instr  input  6  instruction {op[5:4], rx[3:2], ry[1:0]}; captured on accepted run.
- din  input  BUS_W  immediate data for MVI.
- bus  inout  BUS_W  shared bus; driven with din during MVI step, else high-Z.
- r_in  output  NUM_REGS  one-hot load strobe to general registers.
- r_out  output  NUM_REGS  one-hot bus-drive enable to general registers.
- a_in  output  1  load accumulator A from bus.
- g_in  output  1  load G with ALU result.
- g_out  output  1  G drives bus.
- add_sub  output  1  ALU select; 0 = A+bus, 1 = A-bus.
- done  output  1  high in final step of an instruction.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, immediate):
  - State = IDLE, IR = 0.
  - All outputs 0; bus released to high-Z.
  - Reset mid-instruction aborts it with no further strobes.
- States: IDLE, T1, T2, T3; state and IR are registered.
- Outputs are combinational from state and IR (Moore), so each strobe lasts exactly one clock.
- IDLE:
  - run=1 at a rising edge: IR <= instr, next state T1.
  - run=0: stay in IDLE.
  - All outputs 0 in IDLE.
- op 00, MV rx,ry:
  - T1: r_out[ry]=1, r_in[rx]=1, done=1; then IDLE.
- op 01, MVI rx,#din:
  - T1: bus=din, r_in[rx]=1, done=1; then IDLE.
- op 10, ADD rx,ry:
  - T1: r_out[rx]=1, a_in=1.
  - T2: r_out[ry]=1, g_in=1, add_sub=0.
  - T3: g_out=1, r_in[rx]=1, done=1; then IDLE.
- op 11, SUB rx,ry:
  - Identical to ADD except add_sub=1 in T2.
- Latency (run edge to done cycle): MV/MVI 1 cycle; ADD/SUB 3 cycles.
- Arithmetic is external; results wrap modulo 2^BUS_W (e.g. 7+1=0, 0-1=7). The sequencer does no arithmetic.
- Bus exclusivity invariant: in any cycle at most one of {any r_out bit, g_out, internal din drive} is active. r_in and r_out are each one-hot or zero.
- rx==ry is legal:
  - MV R2,R2 gives r_out[2] and r_in[2] high in the same cycle.
  - ADD R1,R1 doubles R1.
- run while busy is ignored. run held high continuously starts a new instruction on the first edge in IDLE, i.e. one idle cycle between instructions.
- instr and din changes while busy have no effect, except that din is passed through live during the MVI T1 cycle.
- add_sub is 0 in every cycle except T2 of SUB.

Test Plan:
- Reset during T2 of ADD R1,R2: assert rst -> all outputs 0 immediately, busy=0; after release, run with MV starts cleanly.
- MVI R3,#5: instr=6'b01_11_00, din=3'b101, pulse run -> next cycle bus=3'b101, r_in=4'b1000, done=1; following cycle busy=0, bus high-Z.
- MV R0,R3: instr=6'b00_00_11 -> one cycle with r_out=4'b1000, r_in=4'b0001, done=1; all other strobes 0.
- ADD R1,R2 with R1=3, R2=6: T1 r_out=0010, a_in=1; T2 r_out=0100, g_in=1, add_sub=0; T3 g_out=1, r_in=0010, done=1 -> R1=1 (wrap).
- SUB R2,R2 with R2=4: add_sub=1 only in T2 -> R2=0 after T3. run held high throughout: the next instruction starts only after one IDLE cycle.
- Random op/rx/ry, 1000 instructions: at most one bus driver per cycle, r_in/r_out one-hot-or-zero, done count equals accepted run count.
